// File: rtl/uart_txfifo_if.sv
// Producer/uart-side signal bundle of the tx byte FIFO.
// The FIFO uses the slave modport; whatever drives it (producer plus uart) uses master.
interface uart_txfifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr;
  logic [7:0]            wdata;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  ovf;
  logic                  ovfclr;
  logic                  flush;
  logic                  txreq;
  logic                  txack;
  logic [7:0]            txdata;

  modport master (
    output wr, wdata, ovfclr, flush, txack,
    input  full, empty, level, ovf, txreq, txdata
  );

  modport slave (
    input  wr, wdata, ovfclr, flush, txack,
    output full, empty, level, ovf, txreq, txdata
  );
endinterface

// File: rtl/uart_txfifo.sv
// Byte FIFO feeding the uart transmitter over txreq/txack/txdata.
// The head byte stays queued and counted until the uart acknowledges it.
module uart_txfifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_txfifo_if.slave  bus
);
  localparam int                   DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rdptr_q, rdptr_d;
  logic [DEPTH_LOG2-1:0] wrptr_q, wrptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  inflight_q, inflight_d;

  logic                  nonempty;
  logic                  full;
  logic                  txreq;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  keep;
  logic [DEPTH_LOG2-1:0] rd_after_pop;

  always_comb begin
    nonempty     = (count_q != '0);
    full         = (count_q == CNT_FULL);
    // Dropping req in the ack cycle keeps the uart from relatching a stale head.
    txreq        = nonempty && !bus.txack;
    pop          = bus.txack && nonempty;
    push         = bus.wr && !full && !bus.flush;
    drop         = bus.wr && full && !bus.flush;
    keep         = (inflight_q || txreq) && !bus.txack;
    rd_after_pop = pop ? rdptr_q + PTR_ONE : rdptr_q;
  end

  always_comb begin
    rdptr_d    = rd_after_pop;
    wrptr_d    = push ? wrptr_q + PTR_ONE : wrptr_q;
    count_d    = count_q;
    inflight_d = keep;
    ovf_d      = ovf_q;

    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    if (bus.flush) begin
      if (keep) begin
        // Head byte already belongs to the uart: keep exactly that one.
        rdptr_d = rdptr_q;
        wrptr_d = rdptr_q + PTR_ONE;
        count_d = CNT_ONE;
      end else begin
        wrptr_d = rd_after_pop;
        count_d = '0;
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovfclr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdptr_q    <= '0;
      wrptr_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      rdptr_q    <= rdptr_d;
      wrptr_q    <= wrptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrptr_q] <= bus.wdata;
    end
  end

  assign bus.txdata = mem[rdptr_q];
  assign bus.txreq  = txreq;
  assign bus.full   = full;
  assign bus.empty  = !nonempty;
  assign bus.level  = count_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_uart_txfifo.sv
// Randomised and directed bench for uart_txfifo against a queue-based model
// of the FIFO plus a simple uart that acknowledges each byte after a fixed time.
module tb_uart_txfifo;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int INT        = 4;

  logic clk;
  logic rst;

  uart_txfifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bif ();

  uart_txfifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: byte queue, in-flight flag, sticky overflow.
  logic [7:0] q[$];
  bit         m_inflight;
  bit         m_ovf;

  // Uart model state.
  bit         u_busy;
  int         u_cnt;
  logic [7:0] sent[$];
  bit         last_txreq;
  logic [7:0] last_txdata;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit ack);
    int n;
    n = q.size();
    expect_eq("level", 32'(bif.level), n);
    expect_eq("full",  32'(bif.full),  32'(n == DEPTH));
    expect_eq("empty", 32'(bif.empty), 32'(n == 0));
    expect_eq("ovf",   32'(bif.ovf),   32'(m_ovf));
    expect_eq("txreq", 32'(bif.txreq), 32'(n != 0 && !ack));
    if (n != 0) expect_eq("txdata", 32'(bif.txdata), 32'(q[0]));
  endtask

  task automatic model_clk(input bit w, input logic [7:0] d, input bit f, input bit oc, input bit ack);
    bit         req;
    bit         keep;
    bit         was_full;
    logic [7:0] head;
    req      = (q.size() != 0) && !ack;
    keep     = (m_inflight || req) && !ack;
    was_full = (q.size() == DEPTH);
    if (f) begin
      if (keep) begin
        head = q[0];
        q.delete();
        q.push_back(head);
      end else begin
        q.delete();
      end
    end else begin
      if (ack && q.size() != 0) void'(q.pop_front());
      if (w && !was_full) q.push_back(d);
    end
    if (w && was_full && !f) m_ovf = 1'b1;
    else if (oc)             m_ovf = 1'b0;
    m_inflight = keep;
  endtask

  // Called at posedge+1; inputs held for one full clock period.
  task automatic cycle(input bit w, input logic [7:0] d, input bit f, input bit oc, input bit ack);
    bif.wr     = w;
    bif.wdata  = d;
    bif.flush  = f;
    bif.ovfclr = oc;
    bif.txack  = ack;
    #4;
    check_outputs(ack);
    last_txreq  = bif.txreq;
    last_txdata = bif.txdata;
    @(posedge clk);
    model_clk(w, d, f, oc, ack);
    #1;
  endtask

  task automatic ucycle(input bit w, input logic [7:0] d);
    bit ack;
    ack = u_busy && (u_cnt == 0);
    cycle(w, d, 1'b0, 1'b0, ack);
    if (ack) begin
      u_busy = 1'b0;
    end else if (u_busy) begin
      u_cnt--;
    end else if (last_txreq) begin
      u_busy = 1'b1;
      u_cnt  = INT * 10 - 1;
      sent.push_back(last_txdata);
      $display("uart tx byte 0x%02h at %0t", last_txdata, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset raised mid-cycle and checked before any clock edge.
  task automatic do_reset();
    bif.wr = 1'b0; bif.wdata = 8'h00; bif.flush = 1'b0; bif.ovfclr = 1'b0; bif.txack = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_inflight = 1'b0;
    m_ovf      = 1'b0;
    u_busy     = 1'b0;
    expect_eq("rst_level", 32'(bif.level), 0);
    expect_eq("rst_empty", 32'(bif.empty), 1);
    expect_eq("rst_txreq", 32'(bif.txreq), 0);
    expect_eq("rst_ovf",   32'(bif.ovf),   0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_abc [3];
    exp_abc[0] = 8'h41; exp_abc[1] = 8'h42; exp_abc[2] = 8'h43;

    rst = 1'b1;
    bif.wr = 1'b0; bif.wdata = 8'h00; bif.flush = 1'b0; bif.ovfclr = 1'b0; bif.txack = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset, then ordered drain through the uart model.
    do_reset();
    sent.delete();
    ucycle(1'b1, 8'h41);
    ucycle(1'b1, 8'h42);
    ucycle(1'b1, 8'h43);
    for (int i = 0; i < 400; i++) begin
      if (sent.size() == 3 && q.size() == 0 && !u_busy) break;
      ucycle(1'b0, 8'h00);
    end
    expect_eq("drain_count", sent.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < sent.size()) expect_eq("drain_byte", 32'(sent[i]), 32'(exp_abc[i]));
    end
    expect_eq("drain_empty", 32'(bif.empty), 1);

    // Overflow with the uart stalled.
    do_reset();
    for (int i = 0; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    expect_eq("ovf_level", 32'(bif.level), 16);
    expect_eq("ovf_full",  32'(bif.full), 1);
    expect_eq("ovf_set",   32'(bif.ovf), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_eq("ovf_clr", 32'(bif.ovf), 0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    expect_eq("ovf_set_wins", 32'(bif.ovf), 1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      idle(1);
    end

    // Accepted write in the txack cycle leaves the level unchanged.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    expect_eq("wrpop_level", 32'(bif.level), 5);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    expect_eq("wrpop_5th", 32'(bif.txdata), 32'h5A);
    idle(1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Flush with the head in flight, then flush coinciding with txack.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    expect_eq("flush_keep", 32'(bif.level), 1);
    idle(2);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    expect_eq("flush_ack", 32'(bif.level), 0);
    idle(2);

    // Late ack after a reset mid-transmission.
    do_reset();
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    idle(2);
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_eq("late_ack_level", 32'(bif.level), 0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    idle(1);
    expect_eq("late_ack_head", 32'(bif.txdata), 32'hC3);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional flush, clear, reset and stray acks.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 55,
              8'($urandom),
              $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 25);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_txfifo.md
Name: uart_txfifo

Overview:
Byte FIFO that buffers bytes from a producer (CPU register, debug logger, packetiser) and drains them into the uart transmitter through its txreq/txack/txdata handshake. Decouples bursty producers from the slow serial line. Sits directly upstream of uart; its tx-side ports connect 1:1 to the uart tx-side ports.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries of 8 bits.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  reset, asynchronous, active-high.
wr  in  1  write strobe; one byte per cycle when high.
wdata  in  8  byte written when wr=1.
full  out  1  level == DEPTH.
empty  out  1  level == 0.
level  out  DEPTH_LOG2+1  number of bytes held, including the byte in flight.
ovf  out  1  sticky overflow flag.
ovfclr  in  1  clears ovf.
flush  in  1  discards all bytes not yet handed to the uart.
txreq  out  1  to uart; request to send head byte.
txack  in  1  from uart; one-cycle pulse when the byte's stop bit completes.
txdata  out  8  to uart; head byte.

Behaviour:
- Storage: DEPTH x 8 array; rdptr, wrptr DEPTH_LOG2 bits, wrap modulo DEPTH; count DEPTH_LOG2+1 bits. level = count.
- Reset (async, immediate): rdptr=0, wrptr=0, count=0, ovf=0, inflight=0. Hence full=0, empty=1, level=0, txreq=0. Array contents are not reset.
- txdata = mem[rdptr], combinational. Valid only when count != 0.
- txreq = (count != 0) && !txack, combinational. Deasserting during the txack cycle is mandatory: uart returns to idle on the same edge that makes txack visible, and would otherwise relatch the stale head byte.
- Head byte stays at rdptr, counted in level, until its txack. No pop before txack.
- inflight register: next = (inflight | txreq) & !txack. A byte is in flight from the first cycle txreq=1 until its txack.
- Pop: txack=1 and count != 0 -> rdptr+1, count-1. txack with count==0 is ignored.
- Write: wr=1 and count<DEPTH and flush=0 -> mem[wrptr]=wdata, wrptr+1, count+1.
- Full is evaluated on the current registered count. wr while full -> byte dropped and ovf set, even if txack pops in the same cycle.
- Simultaneous accepted write and pop: count unchanged; both pointers advance.
- ovf: set on dropped write; cleared by ovfclr. Set wins over clear in the same cycle. Writes ignored during flush do not set ovf.
- Flush, one cycle, registered. Let keep = (inflight | txreq) & !txack.
  - keep=1: the head byte is retained; wrptr=rdptr+1, count=1.
  - keep=0: wrptr=rdptr, count=0. If txack pops in the same cycle, the pop is applied first (rdptr+1) and the queue ends empty.
  - wr in the flush cycle is ignored.
- Latency: a byte written into an empty, idle FIFO gives txreq=1 on the next cycle. Back-to-back bytes have exactly one txreq-low cycle (the txack cycle) between them.
- Reset mid-transmission: FIFO empties immediately. A late txack from the uart arrives with count==0 and is ignored.

Test Plan:
- Reset: assert rst mid-cycle -> level=0, empty=1, txreq=0, ovf=0 without waiting for a clock edge.
- Ordered drain: write 0x41,0x42,0x43 on consecutive cycles with a uart model (INT=4) attached -> serial output A,B,C, each exactly once. txreq is low in each txack cycle. level goes 3,2,1,0.
- Overflow: hold txack=0, write 17 bytes 0x00..0x10 -> level=16, full=1, ovf=1, byte 0x10 absent. Pulse ovfclr -> ovf=0. ovfclr and an overflowing wr in the same cycle -> ovf=1.
- Simultaneous write and pop: level=5, wr=1 with wdata=0x5A in the txack cycle -> level stays 5; 0x5A emerges as the 5th byte after that point.
- Flush: 6 bytes queued, head in flight, pulse flush -> level=1. The in-flight byte completes, txack -> level=0, empty=1, no further txreq. Flush coinciding with txack -> level=0 next cycle.
- Late ack after reset: assert rst while a byte is in flight, then pulse txack with the FIFO empty -> level stays 0, pointers unchanged, txreq=0.
